// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller.
//   - Field positions inside the 24-bit word sent to the 74HC595 chain writer.
//   - Hex glyph table, bit order {g,f,e,d,c,b,a}, active-high.
//   - Scan FSM state type.
package disp_pkg;

    localparam int SEG_MSB = 23;
    localparam int SEL_MSB = 15;
    localparam int LED_MSB = 7;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_SEND_ON        = 3'd1,
        ST_DWELL          = 3'd2,
        ST_SEND_OFF       = 3'd3,
        ST_ADVANCE        = 3'd4,
        ST_SEND_OFF_FINAL = 3'd5
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to 7-segment field decoder.
//   nibble : hex digit 0..F
//   dp     : decimal point request
//   blank  : force the whole field (including dp) off
//   seg    : {dp,g,f,e,d,c,b,a}, active-high
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Glyph lookup with blanking overriding both glyph and decimal point.
    always_comb begin
        if (blank) begin
            seg = 8'h00;
        end else begin
            seg = {dp, SEG_GLYPH[nibble]};
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Each digit period sends one lit word (segments, one-hot select, LEDs) to the
// 74HC595 chain writer and, for brightness below full, a blanked word partway
// through the period.
//   i_CLK, i_RST : clock, synchronous active-high reset
//   i_EN         : scan enable; dropping it finishes the period, blanks, idles
//   i_DIGITS     : nibble per digit, digit k = [4k+3:4k]
//   i_DP/i_BLANK : per-digit decimal point / force-off
//   i_LEDS       : discrete LEDs, sampled live at each send
//   i_BRIGHT     : on-time = (i_BRIGHT+1)/8 of the digit period
//   o_WR_DATA    : word to writer, changes only together with o_WR_VALID
//   o_WR_VALID   : one-cycle load pulse
//   o_FRAME      : one-cycle pulse alongside the digit-0 word after a wrap
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS    = 6,
    parameter int SLOT_CYCLES = 6250,
    parameter int WR_GAP      = 56
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_EN,
    input  logic [4*N_DIGITS-1:0] i_DIGITS,
    input  logic [N_DIGITS-1:0]   i_DP,
    input  logic [N_DIGITS-1:0]   i_BLANK,
    input  logic [7:0]            i_LEDS,
    input  logic [2:0]            i_BRIGHT,
    output logic [23:0]           o_WR_DATA,
    output logic                  o_WR_VALID,
    output logic                  o_FRAME
);

    localparam int PERIOD = 8 * SLOT_CYCLES;
    localparam int PW     = $clog2(PERIOD + 1);
    localparam int IW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(WR_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    scan_state_t           state_r, state_nxt_s;
    logic [PW-1:0]         phase_r, phase_nxt_s, on_end_s;
    logic [IW-1:0]         idx_r, idx_nxt_s;
    logic [4*N_DIGITS-1:0] digits_r, digits_s;
    logic [N_DIGITS-1:0]   dp_r, dp_s, blank_r, blank_s;
    logic [2:0]            bright_r;
    logic                  snap_s, frame_s, send_on_s, send_off_s;
    logic [3:0]            nibble_s;
    logic                  dp_bit_s, blank_bit_s;
    logic [7:0]            seg_s, sel_s;
    logic [23:0]           word_s;

    // Last phase value of the lit part of the period; the blank word lands one
    // cycle later, at phase (bright+1)*SLOT_CYCLES.
    always_comb begin
        on_end_s = PW'((int'(bright_r) + 1) * SLOT_CYCLES - 1);
    end

    // Next-state, phase, digit index and snapshot/frame strobes.
    // phase_r equals the number of cycles since the current SEND_ON cycle, so
    // ADVANCE falls on phase 8*SLOT_CYCLES and the period is 8*SLOT_CYCLES+1.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r + PW'(1);
        idx_nxt_s   = idx_r;
        snap_s      = 1'b0;
        frame_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_nxt_s = '0;
                if (i_EN) begin
                    snap_s      = 1'b1;
                    idx_nxt_s   = '0;
                    state_nxt_s = ST_SEND_ON;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND_ON: begin
                state_nxt_s = ST_DWELL;
            end
            ST_DWELL: begin
                if (phase_r == PHASE_LAST) begin
                    state_nxt_s = ST_ADVANCE;
                end else if ((bright_r != 3'd7) && (phase_r == on_end_s)) begin
                    state_nxt_s = ST_SEND_OFF;
                end else begin
                    state_nxt_s = ST_DWELL;
                end
            end
            ST_SEND_OFF: begin
                state_nxt_s = ST_DWELL;
            end
            ST_ADVANCE: begin
                phase_nxt_s = '0;
                if (!i_EN) begin
                    state_nxt_s = ST_SEND_OFF_FINAL;
                end else if (idx_r == IDX_LAST) begin
                    idx_nxt_s   = '0;
                    snap_s      = 1'b1;
                    frame_s     = 1'b1;
                    state_nxt_s = ST_SEND_ON;
                end else begin
                    idx_nxt_s   = idx_r + IW'(1);
                    state_nxt_s = ST_SEND_ON;
                end
            end
            ST_SEND_OFF_FINAL: begin
                // Hold off a restart until the writer has shifted the blank out.
                if (phase_r == GAP_LAST) begin
                    phase_nxt_s = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND_OFF_FINAL;
                end
            end
            default: begin
                phase_nxt_s = '0;
                idx_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered against the next state, so the word is decoded
    // from the snapshot as it will be after this edge.
    always_comb begin
        digits_s    = snap_s ? i_DIGITS : digits_r;
        dp_s        = snap_s ? i_DP     : dp_r;
        blank_s     = snap_s ? i_BLANK  : blank_r;
        nibble_s    = digits_s[{idx_nxt_s, 2'b00} +: 4];
        dp_bit_s    = dp_s[idx_nxt_s];
        blank_bit_s = blank_s[idx_nxt_s];
        sel_s       = 8'b0000_0001 << idx_nxt_s;
        send_on_s   = (state_nxt_s == ST_SEND_ON);
        send_off_s  = (state_nxt_s == ST_SEND_OFF) ||
                      ((state_nxt_s == ST_SEND_OFF_FINAL) && (state_r != ST_SEND_OFF_FINAL));
    end

    seg7_decode u_seg7 (
        .nibble (nibble_s),
        .dp     (dp_bit_s),
        .blank  (blank_bit_s),
        .seg    (seg_s)
    );

    // Assemble the lit or blanked word; LEDs always come from the live input.
    always_comb begin
        word_s                 = 24'h00_0000;
        word_s[LED_MSB -: 8]   = i_LEDS;
        if (send_on_s) begin
            word_s[SEG_MSB -: 8] = seg_s;
            word_s[SEL_MSB -: 8] = sel_s;
        end else begin
            word_s[SEG_MSB -: 8] = 8'h00;
            word_s[SEL_MSB -: 8] = 8'h00;
        end
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r    <= ST_IDLE;
            phase_r    <= '0;
            idx_r      <= '0;
            digits_r   <= '0;
            dp_r       <= '0;
            blank_r    <= '0;
            bright_r   <= 3'd0;
            o_WR_DATA  <= 24'h00_0000;
            o_WR_VALID <= 1'b0;
            o_FRAME    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            phase_r    <= phase_nxt_s;
            idx_r      <= idx_nxt_s;
            o_WR_VALID <= send_on_s | send_off_s;
            o_FRAME    <= frame_s;
            if (snap_s) begin
                digits_r <= i_DIGITS;
                dp_r     <= i_DP;
                blank_r  <= i_BLANK;
                bright_r <= i_BRIGHT;
            end
            if (send_on_s || send_off_s) begin
                o_WR_DATA <= word_s;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

    localparam int N     = 6;
    localparam int SLOT  = 100;
    localparam int GAP   = 56;
    localparam int PER   = 8 * SLOT + 1;
    localparam int NEVER = 32'h7FFF_FFFF;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [23:0] digits;
        logic [5:0]  dp;
        logic [5:0]  blank;
        logic [2:0]  bright;
        logic [7:0]  leds;
    } cfg_t;

    typedef struct packed {
        cfg_t        cfg;
        logic [23:0] w0;
        logic [23:0] w1;
    } vec_t;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic        i_EN = 1'b0;
    logic [23:0] i_DIGITS = 24'h0;
    logic [5:0]  i_DP = 6'h0;
    logic [5:0]  i_BLANK = 6'h0;
    logic [7:0]  i_LEDS = 8'h0;
    logic [2:0]  i_BRIGHT = 3'd0;
    logic [23:0] o_WR_DATA;
    logic        o_WR_VALID;
    logic        o_FRAME;

    disp_scan_ctrl #(.N_DIGITS(N), .SLOT_CYCLES(SLOT), .WR_GAP(GAP)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_EN(i_EN), .i_DIGITS(i_DIGITS),
        .i_DP(i_DP), .i_BLANK(i_BLANK), .i_LEDS(i_LEDS), .i_BRIGHT(i_BRIGHT),
        .o_WR_DATA(o_WR_DATA), .o_WR_VALID(o_WR_VALID), .o_FRAME(o_FRAME)
    );

    always #5 i_CLK = ~i_CLK;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge i_CLK) begin
        cyc   <= cyc + 1;
        rst_q <= i_RST;
    end

    int          tests = 0;
    int          fails = 0;
    int          last_t = -1;
    logic [23:0] prev_d = 24'h0;
    int          ev_t[$];
    logic [23:0] ev_d[$];
    logic        ev_f[$];
    int          xt[$];
    logic [23:0] xd[$];
    logic        xf[$];

    // One cycle: advance to the falling edge and run the continuous checks.
    task automatic tick();
        @(negedge i_CLK);
        if (rst_q) begin
            last_t = -1;
        end else begin
            tests++;
            if (!o_WR_VALID && o_WR_DATA != prev_d) begin
                fails++;
                $display("FAIL hold @%0d: data %h changed from %h without valid", cyc, o_WR_DATA, prev_d);
            end
            tests++;
            if (o_FRAME && !o_WR_VALID) begin
                fails++;
                $display("FAIL frame_alone @%0d: o_FRAME=1 with o_WR_VALID=0, required both", cyc);
            end
            if (o_WR_VALID) begin
                if (last_t >= 0) begin
                    tests++;
                    if (cyc - last_t < GAP) begin
                        fails++;
                        $display("FAIL spacing @%0d: gap %0d, required >= %0d", cyc, cyc - last_t, GAP);
                    end
                end
                last_t = cyc;
                ev_t.push_back(cyc);
                ev_d.push_back(o_WR_DATA);
                ev_f.push_back(o_FRAME);
            end
        end
        prev_d = o_WR_DATA;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clear_log();
        ev_t.delete(); ev_d.delete(); ev_f.delete();
    endtask

    task automatic do_reset();
        i_RST = 1'b1;
        i_EN  = 1'b0;
        tick();
        tick();
        i_RST = 1'b0;
        clear_log();
    endtask

    task automatic apply(input cfg_t c);
        i_DIGITS = c.digits;
        i_DP     = c.dp;
        i_BLANK  = c.blank;
        i_BRIGHT = c.bright;
        i_LEDS   = c.leds;
    endtask

    function automatic logic [23:0] on_word(input cfg_t c, input int k, input logic [7:0] leds);
        logic [3:0]  nib;
        logic [7:0]  seg;
        logic [7:0]  sel;
        logic [23:0] dg;
        dg  = c.digits;
        nib = dg[4*k +: 4];
        if (c.blank[k]) seg = 8'h00;
        else            seg = {c.dp[k], GLYPH[nib]};
        sel    = 8'h00;
        sel[k] = 1'b1;
        return {seg, sel, leds};
    endfunction

    // Expected writes: frame 0 uses snapshot a, later frames use b; LEDs
    // switch from a to b for sends after cycle tc.
    task automatic build_expected(input int t0, input int np, input cfg_t a, input cfg_t b, input int tc);
        xt.delete(); xd.delete(); xf.delete();
        for (int p = 0; p < np; p++) begin
            cfg_t c;
            int   k;
            int   tp;
            int   tb;
            c  = (p < N) ? a : b;
            k  = p % N;
            tp = t0 + p * PER;
            xt.push_back(tp);
            xd.push_back(on_word(c, k, (tp > tc) ? b.leds : a.leds));
            xf.push_back(p > 0 && k == 0);
            if (c.bright != 3'd7) begin
                tb = tp + (int'(c.bright) + 1) * SLOT;
                xt.push_back(tb);
                xd.push_back({16'h0000, (tb > tc) ? b.leds : a.leds});
                xf.push_back(1'b0);
            end
        end
    endtask

    task automatic compare_events(input string name, input int limit);
        int n;
        int m;
        n = 0;
        foreach (ev_t[i]) if (ev_t[i] < limit) n++;
        tests++;
        if (n != xt.size()) begin
            fails++;
            $display("FAIL %s count: got %0d writes, required %0d", name, n, xt.size());
        end
        m = (n < xt.size()) ? n : xt.size();
        for (int i = 0; i < m; i++) begin
            tests++;
            if (ev_t[i] != xt[i] || ev_d[i] !== xd[i] || ev_f[i] !== xf[i]) begin
                fails++;
                $display("FAIL %s ev%0d: got t=%0d d=%h f=%b, required t=%0d d=%h f=%b",
                         name, i, ev_t[i], ev_d[i], ev_f[i], xt[i], xd[i], xf[i]);
            end
        end
    endtask

    task automatic check_word_at(input string name, input int t, input logic [23:0] w);
        int idx;
        idx = -1;
        foreach (ev_t[i]) if (ev_t[i] == t) idx = i;
        tests++;
        if (idx < 0) begin
            fails++;
            $display("FAIL %s: no write at cycle %0d, required %h", name, t, w);
        end else if (ev_d[idx] !== w) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, ev_d[idx], w);
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.digits = 24'($urandom);
        c.dp     = 6'($urandom);
        c.blank  = 6'($urandom);
        c.bright = 3'($urandom_range(0, 7));
        c.leds   = 8'($urandom);
        return c;
    endfunction

    vec_t vecs [4];

    initial begin
        cfg_t a;
        cfg_t b;
        int   t0;
        int   tc;

        vecs[0] = '{cfg: '{24'h654321, 6'b000000, 6'b000000, 3'd7, 8'hA5}, w0: 24'h06_01_A5, w1: 24'h5B_02_A5};
        vecs[1] = '{cfg: '{24'h654321, 6'b000000, 6'b000000, 3'd3, 8'hA5}, w0: 24'h06_01_A5, w1: 24'h5B_02_A5};
        vecs[2] = '{cfg: '{24'h654321, 6'b000001, 6'b000010, 3'd7, 8'h3C}, w0: 24'h86_01_3C, w1: 24'h00_02_3C};
        vecs[3] = '{cfg: '{24'hFEDCBA, 6'b000000, 6'b000000, 3'd0, 8'h81}, w0: 24'h77_01_81, w1: 24'h7C_02_81};

        // Reset state.
        tick();
        tests++;
        if (o_WR_DATA !== 24'h0 || o_WR_VALID !== 1'b0 || o_FRAME !== 1'b0) begin
            fails++;
            $display("FAIL reset: got data=%h valid=%b frame=%b, required all 0", o_WR_DATA, o_WR_VALID, o_FRAME);
        end

        // Table vectors: two digit periods each.
        foreach (vecs[i]) begin
            do_reset();
            apply(vecs[i].cfg);
            i_EN = 1'b1;
            t0 = cyc + 1;
            wait_until(t0 + 2 * PER);
            build_expected(t0, 2, vecs[i].cfg, vecs[i].cfg, NEVER);
            compare_events($sformatf("vec%0d", i), t0 + 2 * PER);
            check_word_at($sformatf("vec%0d_w0", i), t0, vecs[i].w0);
            check_word_at($sformatf("vec%0d_w1", i), t0 + PER, vecs[i].w1);
        end

        // Mid-frame change during digit 2: two full frames plus one digit.
        do_reset();
        a = '{24'h654321, 6'b000000, 6'b000000, 3'd3, 8'hA5};
        b = '{24'h9ABCDE, 6'b100100, 6'b000001, 3'd5, 8'h5A};
        apply(a);
        i_EN = 1'b1;
        t0 = cyc + 1;
        tc = t0 + 2 * PER + 50;
        wait_until(tc);
        apply(b);
        wait_until(t0 + 13 * PER);
        build_expected(t0, 13, a, b, tc);
        compare_events("snapshot", t0 + 13 * PER);

        // Randomized runs checked against the reference model.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            a = rand_cfg();
            b = rand_cfg();
            apply(a);
            i_EN = 1'b1;
            t0 = cyc + 1;
            tc = t0 + 2 * PER + 50;
            wait_until(tc);
            apply(b);
            wait_until(t0 + 7 * PER);
            build_expected(t0, 7, a, b, tc);
            compare_events($sformatf("rand%0d", r), t0 + 7 * PER);
        end

        // Reset pulse during DWELL with i_EN held high.
        do_reset();
        a = '{24'h654321, 6'b000000, 6'b000000, 3'd7, 8'hC3};
        apply(a);
        i_EN = 1'b1;
        t0 = cyc + 1;
        wait_until(t0 + 200);
        i_RST = 1'b1;
        tick();
        tests++;
        if (o_WR_DATA !== 24'h0 || o_WR_VALID !== 1'b0 || o_FRAME !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got data=%h valid=%b frame=%b, required all 0", o_WR_DATA, o_WR_VALID, o_FRAME);
        end
        i_RST = 1'b0;
        clear_log();
        t0 = cyc + 1;
        wait_until(t0 + 2 * PER);
        build_expected(t0, 2, a, a, NEVER);
        compare_events("restart", t0 + 2 * PER);

        // i_EN drop in the middle of digit 1.
        do_reset();
        a = '{24'h654321, 6'b000000, 6'b000000, 3'd7, 8'h99};
        apply(a);
        i_EN = 1'b1;
        t0 = cyc + 1;
        wait_until(t0 + PER + 300);
        i_EN = 1'b0;
        wait_until(t0 + 12 * PER);
        xt.delete(); xd.delete(); xf.delete();
        xt.push_back(t0);           xd.push_back(on_word(a, 0, a.leds)); xf.push_back(1'b0);
        xt.push_back(t0 + PER);     xd.push_back(on_word(a, 1, a.leds)); xf.push_back(1'b0);
        xt.push_back(t0 + 2 * PER); xd.push_back({16'h0000, a.leds});    xf.push_back(1'b0);
        compare_events("en_drop", NEVER);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
